// File: rtl/ota_cmp_decimator.sv
// Comparator post-processing: synchronise, debounce, then measure ones-density and
// clean-transition count over a 2^WIN_LOG2-strobe window with a valid/ready result port.
module ota_cmp_decimator #(
  parameter int WIN_LOG2 = 4,
  parameter int DEB_LEN  = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_cmp_in,
  input  logic                i_sample_en,
  input  logic                i_start,
  input  logic                i_cont,
  input  logic                i_ovr_clr,
  output logic                o_cmp_sync,
  output logic                o_cmp_clean,
  output logic                o_busy,
  output logic [WIN_LOG2:0]   o_density,
  output logic [7:0]          o_toggles,
  output logic                o_dens_valid,
  input  logic                i_dens_ready,
  output logic                o_overrun
);

  localparam int N = 1 << WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] SAMP_LAST = WIN_LOG2'(N - 1);
  localparam logic [3:0]          DEB_LAST  = 4'(DEB_LEN - 1);

  typedef enum logic {S_IDLE = 1'b0, S_ACQ = 1'b1} state_t;

  state_t              r_state;
  logic                r_sync1, r_sync2, r_clean;
  logic [3:0]          r_deb_cnt;
  logic [WIN_LOG2:0]   r_acc, r_density;
  logic [7:0]          r_tog, r_toggles;
  logic [WIN_LOG2-1:0] r_samp_cnt;
  logic                r_dens_valid, r_overrun;

  state_t              w_state_nxt;
  logic                w_strobe, w_diff, w_flip, w_load, w_accept;
  logic                w_clean_nxt, w_valid_nxt, w_overrun_nxt;
  logic [3:0]          w_deb_nxt;
  logic [WIN_LOG2:0]   w_acc_nxt, w_acc_fin;
  logic [7:0]          w_tog_nxt, w_tog_fin;
  logic [WIN_LOG2-1:0] w_samp_nxt;

  assign w_strobe = i_sample_en & i_en;
  assign w_diff   = r_sync2 ^ r_clean;
  assign w_flip   = w_strobe & w_diff & (r_deb_cnt == DEB_LAST);
  assign w_accept = r_dens_valid & i_dens_ready;

  // Debounce: count consecutive differing strobes, invert on the DEB_LEN-th.
  always_comb begin
    w_clean_nxt = r_clean;
    w_deb_nxt   = r_deb_cnt;
    if (w_strobe) begin
      if (w_flip) begin
        w_clean_nxt = ~r_clean;
        w_deb_nxt   = 4'd0;
      end else if (w_diff) begin
        w_deb_nxt   = r_deb_cnt + 4'd1;
      end else begin
        w_deb_nxt   = 4'd0;
      end
    end else begin
      w_deb_nxt   = r_deb_cnt;
    end
  end

  // Window FSM next-state and accumulators; the final strobe's contribution is folded in.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_tog_nxt   = r_tog;
    w_samp_nxt  = r_samp_cnt;
    w_load      = 1'b0;
    w_acc_fin   = r_acc + {{WIN_LOG2{1'b0}}, r_clean};
    w_tog_fin   = (w_flip && (r_tog != 8'hFF)) ? (r_tog + 8'd1) : r_tog;
    case (r_state)
      S_IDLE: begin
        if (i_start && i_en) begin
          w_state_nxt = S_ACQ;
          w_acc_nxt   = '0;
          w_tog_nxt   = 8'd0;
          w_samp_nxt  = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACQ: begin
        if (w_strobe) begin
          if (r_samp_cnt == SAMP_LAST) begin
            w_load      = 1'b1;
            w_acc_nxt   = '0;
            w_tog_nxt   = 8'd0;
            w_samp_nxt  = '0;
            w_state_nxt = i_cont ? S_ACQ : S_IDLE;
          end else begin
            w_acc_nxt   = w_acc_fin;
            w_tog_nxt   = w_tog_fin;
            w_samp_nxt  = r_samp_cnt + {{(WIN_LOG2-1){1'b0}}, 1'b1};
          end
        end else begin
          w_state_nxt = S_ACQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Result handshake: a load beats a same-cycle accept; overrun set beats clear.
  always_comb begin
    w_valid_nxt   = r_dens_valid;
    w_overrun_nxt = r_overrun;
    if (w_load) begin
      w_valid_nxt = 1'b1;
    end else if (w_accept) begin
      w_valid_nxt = 1'b0;
    end else begin
      w_valid_nxt = r_dens_valid;
    end
    if (w_load && r_dens_valid && !w_accept) begin
      w_overrun_nxt = 1'b1;
    end else if (i_ovr_clr) begin
      w_overrun_nxt = 1'b0;
    end else begin
      w_overrun_nxt = r_overrun;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_clean      <= 1'b0;
      r_deb_cnt    <= 4'd0;
      r_acc        <= '0;
      r_tog        <= 8'd0;
      r_samp_cnt   <= '0;
      r_density    <= '0;
      r_toggles    <= 8'd0;
      r_dens_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sync1      <= i_cmp_in;
      r_sync2      <= r_sync1;
      r_clean      <= w_clean_nxt;
      r_deb_cnt    <= w_deb_nxt;
      r_acc        <= w_acc_nxt;
      r_tog        <= w_tog_nxt;
      r_samp_cnt   <= w_samp_nxt;
      r_dens_valid <= w_valid_nxt;
      r_overrun    <= w_overrun_nxt;
      if (w_load) begin
        r_density <= w_acc_fin;
        r_toggles <= w_tog_fin;
      end
    end
  end

  assign o_cmp_sync   = r_sync2;
  assign o_cmp_clean  = r_clean;
  assign o_busy       = (r_state == S_ACQ);
  assign o_density    = r_density;
  assign o_toggles    = r_toggles;
  assign o_dens_valid = r_dens_valid;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_ota_cmp_decimator.sv
// Directed bench for ota_cmp_decimator: results are checked by a scoreboard monitor at
// each accepted handshake, control outputs by inline checks.
module tb_ota_cmp_decimator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1, cmp_in = 1'b1, sample_en = 1'b1, start = 1'b0;
  logic       cont = 1'b0, ovr_clr = 1'b0, dens_ready = 1'b0;
  logic       cmp_sync, cmp_clean, busy, dens_valid, overrun;
  logic [4:0] density;
  logic [7:0] toggles;

  int errors = 0;
  int checks = 0;
  logic [12:0] sb[$];

  always #5 clk = ~clk;

  ota_cmp_decimator #(.WIN_LOG2(4), .DEB_LEN(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_cmp_in(cmp_in), .i_sample_en(sample_en),
    .i_start(start), .i_cont(cont), .i_ovr_clr(ovr_clr),
    .o_cmp_sync(cmp_sync), .o_cmp_clean(cmp_clean), .o_busy(busy),
    .o_density(density), .o_toggles(toggles), .o_dens_valid(dens_valid),
    .i_dens_ready(dens_ready), .o_overrun(overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: compare the presented result against the scoreboard on every accept.
  always @(negedge clk) begin
    if (!rst && dens_valid && dens_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got dens=%0d tog=%0d with nothing expected", density, toggles);
      end else begin
        logic [12:0] e;
        e = sb.pop_front();
        if ({density, toggles} != e) begin
          errors++;
          $display("FAIL sb_result: got dens=%0d tog=%0d expected dens=%0d tog=%0d",
                   density, toggles, e[12:8], e[7:0]);
        end
      end
    end
  end

  task automatic run_window(input string nm);
    int n = 0;
    int busy_cycles = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (busy && n < 100) begin
      busy_cycles++;
      step();
      n++;
    end
    check({nm, "_busy_cycles"}, busy_cycles, 16);
    check({nm, "_valid"}, dens_valid, 1);
  endtask

  task automatic accept(input logic [4:0] d, input logic [7:0] t);
    sb.push_back({d, t});
    dens_ready = 1'b1;
    step();
    dens_ready = 1'b0;
  endtask

  initial begin
    // 1: reset with cmp_in high
    step(); step();
    check("rst_density", density, 0);
    check("rst_toggles", toggles, 0);
    check("rst_valid", dens_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_sync", cmp_sync, 0);
    check("rst_clean", cmp_clean, 0);
    rst = 1'b0;
    step(); step();
    check("sync_after_2", cmp_sync, 1);

    // 2: constant one
    repeat (10) step();
    check("t2_clean_pre", cmp_clean, 1);
    run_window("t2");
    accept(5'd16, 8'd0);
    check("t2_valid_drop", dens_valid, 0);

    // 3: square wave, period 8 samples
    cmp_in = 1'b0;
    repeat (10) step();
    check("t3_clean_pre", cmp_clean, 0);
    for (int c = 0; c < 60; c++) begin
      cmp_in = ((c / 4) % 2) == 0;
      start  = (c == 20);
      step();
    end
    start = 1'b0;
    check("t3_valid", dens_valid, 1);
    accept(5'd8, 8'd4);

    // 4: two-sample glitches every six samples
    begin
      int clean_hi = 0;
      cmp_in = 1'b0;
      repeat (10) step();
      for (int c = 0; c < 48; c++) begin
        cmp_in = (c % 6) < 2;
        start  = (c == 12);
        step();
        if (cmp_clean) clean_hi++;
      end
      start = 1'b0;
      check("t4_clean_never_high", clean_hi, 0);
      check("t4_valid", dens_valid, 1);
      accept(5'd0, 8'd0);
    end

    // 5: continuous mode, overrun, coincident load and accept
    cmp_in = 1'b1;
    cont = 1'b1;
    repeat (10) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (16) step();
    check("t5_w1_valid", dens_valid, 1);
    check("t5_w1_overrun", overrun, 0);
    repeat (16) step();
    check("t5_w2_overrun", overrun, 1);
    check("t5_w2_density", density, 16);
    check("t5_w2_valid", dens_valid, 1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("t5_ovr_clr", overrun, 0);
    repeat (14) step();
    accept(5'd16, 8'd0);
    check("t5_coinc_valid", dens_valid, 1);
    check("t5_coinc_overrun", overrun, 0);
    cont = 1'b0;
    accept(5'd16, 8'd0);
    check("t5_drain_valid", dens_valid, 0);
    begin
      int n = 0;
      while (!dens_valid && n < 40) begin
        step();
        n++;
      end
    end
    check("t5_w4_valid", dens_valid, 1);
    check("t5_w4_overrun", overrun, 0);
    check("t5_w4_idle", busy, 0);

    // 6: reset mid-window discards the partial window
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    check("t6_busy_pre", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_valid", dens_valid, 0);
    check("t6_density", density, 0);
    repeat (8) step();
    run_window("t6");
    accept(5'd16, 8'd0);

    repeat (3) step();
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
